// File: rtl/uart_pkg.sv
// uart_pkg: shared types, constants and helpers for the parametrised UART.
//   uart_state_e : frame state shared by the TX and RX FSMs
//   OVERSAMPLE   : ticks per bit period
//   HALF_BIT     : ticks from a start edge to the start-bit centre
//   calc_div     : clocks per tick, CLK_FREQ/(BAUD*16), truncated, minimum 1
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned HALF_BIT   = 8;

  function automatic int unsigned calc_div(input int unsigned clk_freq, input int unsigned baud);
    int unsigned d;
    d = clk_freq / (baud * OVERSAMPLE);
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: oversampling tick generator.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   clr  : restart the divider (next tick DIV clocks after clr drops)
//   tick : one-cycle pulse every DIV clocks
module uart_baud_gen #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CntW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_param_trx.sv
// uart_param_trx: parametrised full-duplex UART, 16x oversampled receiver.
//   clk, rst           : system clock, asynchronous active-low reset
//   tx_start, tx_data  : send request (taken only while tx_busy=0) and word
//   p_sel              : parity select, 0 even / 1 odd
//   tx, tx_busy        : serial output (idle high), frame in progress
//   rx                 : asynchronous serial input
//   rx_data, rx_valid  : last received word, one-cycle update strobe
//   p_err, f_err       : parity / framing error of the last frame
// Optional feature: define UART_PARITY_EN to add a parity bit to every frame.
// Without it the parity states are absent, p_sel is ignored and p_err is 0.
module uart_param_trx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD      = 115_200,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              p_sel,
  output logic              tx,
  output logic              tx_busy,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              p_err,
  output logic              f_err
);

  localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD);

  // ---------------------------------------------------------------- TX
  uart_state_e       tx_state_q, tx_state_d;
  logic [3:0]        tx_os_q, tx_os_d;
  logic [3:0]        tx_bit_q, tx_bit_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic              tx_q, tx_d;
  logic              tx_busy_q, tx_busy_d;
  logic              tx_tick, tx_clr, tx_bit_end;
`ifdef UART_PARITY_EN
  logic              tx_par_q, tx_par_d;
`endif

  assign tx_clr = (tx_state_q == StIdle);

  uart_baud_gen #(.DIV(DIV)) u_tx_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (tx_clr),
    .tick (tx_tick)
  );

  always_comb begin
    tx_state_d = tx_state_q;
    tx_os_d    = tx_os_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_d       = tx_q;
    tx_busy_d  = tx_busy_q;
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    tx_bit_end = tx_tick && (tx_os_q == 4'(OVERSAMPLE - 1));
    if (tx_tick && (tx_state_q != StIdle)) begin
      tx_os_d = tx_bit_end ? 4'd0 : tx_os_q + 4'd1;
    end
    unique case (tx_state_q)
      StIdle: begin
        if (tx_start) begin
          tx_sh_d    = tx_data;
`ifdef UART_PARITY_EN
          tx_par_d   = ^tx_data ^ p_sel;
`endif
          tx_os_d    = '0;
          tx_bit_d   = '0;
          tx_d       = 1'b0;
          tx_busy_d  = 1'b1;
          tx_state_d = StStart;
        end
      end
      StStart: begin
        if (tx_bit_end) begin
          tx_d       = tx_sh_q[0];
          tx_bit_d   = '0;
          tx_state_d = StData;
        end
      end
      StData: begin
        if (tx_bit_end) begin
          if (tx_bit_q == 4'(DATA_W - 1)) begin
            tx_bit_d   = '0;
`ifdef UART_PARITY_EN
            tx_d       = tx_par_q;
            tx_state_d = StParity;
`else
            tx_d       = 1'b1;
            tx_state_d = StStop;
`endif
          end else begin
            tx_sh_d  = tx_sh_q >> 1;
            tx_d     = tx_sh_q[1];
            tx_bit_d = tx_bit_q + 4'd1;
          end
        end
      end
`ifdef UART_PARITY_EN
      StParity: begin
        if (tx_bit_end) begin
          tx_d       = 1'b1;
          tx_bit_d   = '0;
          tx_state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (tx_bit_end) begin
          if (tx_bit_q == 4'(STOP_BITS - 1)) begin
            tx_busy_d  = 1'b0;
            tx_state_d = StIdle;
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
          end
        end
      end
      default: tx_state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------- RX
  uart_state_e       rx_state_q, rx_state_d;
  logic [3:0]        rx_os_q, rx_os_d;
  logic [3:0]        rx_bit_q, rx_bit_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              f_err_q, f_err_d;
  logic              rx_meta_q, rx_sync_q;
  logic              rx_tick, rx_clr, rx_half_end, rx_bit_end;
`ifdef UART_PARITY_EN
  logic              rx_psel_q, rx_psel_d;
  logic              rx_rpar_q, rx_rpar_d;
  logic              p_err_q, p_err_d;
`else
  logic              unused_p_sel;
  assign unused_p_sel = p_sel;
`endif

  assign rx_clr = (rx_state_q == StIdle);

  uart_baud_gen #(.DIV(DIV)) u_rx_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (rx_clr),
    .tick (rx_tick)
  );

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_os_d     = rx_os_q;
    rx_bit_d    = rx_bit_q;
    rx_sh_d     = rx_sh_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    f_err_d     = f_err_q;
`ifdef UART_PARITY_EN
    rx_psel_d   = rx_psel_q;
    rx_rpar_d   = rx_rpar_q;
    p_err_d     = p_err_q;
`endif
    rx_half_end = rx_tick && (rx_state_q == StStart) && (rx_os_q == 4'(HALF_BIT - 1));
    rx_bit_end  = rx_tick && (rx_state_q != StStart) && (rx_os_q == 4'(OVERSAMPLE - 1));
    if (rx_tick && (rx_state_q != StIdle)) begin
      rx_os_d = (rx_half_end || rx_bit_end) ? 4'd0 : rx_os_q + 4'd1;
    end
    unique case (rx_state_q)
      StIdle: begin
        if (!rx_sync_q) begin
          rx_os_d    = '0;
`ifdef UART_PARITY_EN
          rx_psel_d  = p_sel;
`endif
          rx_state_d = StStart;
        end
      end
      StStart: begin
        // Line back high at the start-bit centre means a glitch: drop it silently.
        if (rx_half_end) begin
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? StIdle : StData;
        end
      end
      StData: begin
        if (rx_bit_end) begin
          rx_sh_d = {rx_sync_q, rx_sh_q[DATA_W-1:1]};
          if (rx_bit_q == 4'(DATA_W - 1)) begin
`ifdef UART_PARITY_EN
            rx_state_d = StParity;
`else
            rx_state_d = StStop;
`endif
          end else begin
            rx_bit_d = rx_bit_q + 4'd1;
          end
        end
      end
`ifdef UART_PARITY_EN
      StParity: begin
        if (rx_bit_end) begin
          rx_rpar_d  = rx_sync_q;
          rx_state_d = StStop;
        end
      end
`endif
      StStop: begin
        // Only the first stop bit is checked; the FSM is back in idle before any second one.
        if (rx_bit_end) begin
          rx_data_d  = rx_sh_q;
          f_err_d    = !rx_sync_q;
`ifdef UART_PARITY_EN
          p_err_d    = (^rx_sh_q ^ rx_psel_q) != rx_rpar_q;
`endif
          rx_valid_d = 1'b1;
          rx_state_d = StIdle;
        end
      end
      default: rx_state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= StIdle;
      tx_os_q    <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= StIdle;
      rx_os_q    <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      f_err_q    <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
      rx_psel_q  <= 1'b0;
      rx_rpar_q  <= 1'b0;
      p_err_q    <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_os_q    <= tx_os_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_q       <= tx_d;
      tx_busy_q  <= tx_busy_d;
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_os_q    <= rx_os_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      f_err_q    <= f_err_d;
`ifdef UART_PARITY_EN
      tx_par_q   <= tx_par_d;
      rx_psel_q  <= rx_psel_d;
      rx_rpar_q  <= rx_rpar_d;
      p_err_q    <= p_err_d;
`endif
    end
  end

  assign tx       = tx_q;
  assign tx_busy  = tx_busy_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign f_err    = f_err_q;
`ifdef UART_PARITY_EN
  assign p_err    = p_err_q;
`else
  assign p_err    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_param_trx.sv
// tb_uart_param_trx: self-checking bench for uart_param_trx at DIV=1 (16 clocks/bit).
// Expected RX results are queued when a frame is launched and compared on rx_valid.
module tb_uart_param_trx;

  localparam int unsigned CLK_FREQ  = 1_600_000;
  localparam int unsigned BAUD      = 100_000;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned STOP_BITS = 1;
  localparam int unsigned BIT_CLKS  = 16;
`ifdef UART_PARITY_EN
  localparam int unsigned P = 1;
`else
  localparam int unsigned P = 0;
`endif
  localparam int unsigned FRAME_BITS = 1 + DATA_W + P + STOP_BITS;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              p_err;
    logic              f_err;
  } rx_exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic              p_sel;
  logic              tx;
  logic              tx_busy;
  logic              rx;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              p_err;
  logic              f_err;
  logic              loop;
  logic              rx_drv;

  rx_exp_t sb_q[$];
  int      n_total    = 0;
  int      n_bad      = 0;
  int      n_rx_valid = 0;

  always #5 clk = ~clk;

  assign rx = loop ? tx : rx_drv;

  uart_param_trx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .DATA_W    (DATA_W),
    .STOP_BITS (STOP_BITS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .p_sel    (p_sel),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .p_err    (p_err),
    .f_err    (f_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard side: every rx_valid must match the oldest queued expectation.
  always @(negedge clk) begin : rx_mon
    rx_exp_t e;
    if (rst && rx_valid) begin
      n_rx_valid++;
      if (sb_q.size() == 0) begin
        check_eq("rx_unexpected", 32'(rx_valid), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("rx_data", 32'(rx_data), 32'(e.data));
        check_eq("rx_p_err", 32'(p_err), 32'(e.p_err));
        check_eq("rx_f_err", 32'(f_err), 32'(e.f_err));
      end
    end
  end

  // Accept edge happens inside; returns #1 after it.
  task automatic pulse_tx(input logic [DATA_W-1:0] d, input logic ps);
    @(negedge clk);
    tx_data  = d;
    p_sel    = ps;
    tx_start = 1'b1;
    @(posedge clk);
    #1 tx_start = 1'b0;
  endtask

  task automatic check_tx_frame(input logic [DATA_W-1:0] d, input logic ps);
    logic [15:0] bits;
    int          busy_cnt;
    busy_cnt = 0;
    bits     = '1;
    bits[0]  = 1'b0;
    for (int i = 0; i < int'(DATA_W); i++) bits[1+i] = d[i];
    if (P != 0) bits[1+DATA_W] = ^d ^ ps;
    pulse_tx(d, ps);
    check_eq("tx_start_bit", 32'(tx), 32'd0);
    for (int i = 0; i < int'(FRAME_BITS * BIT_CLKS) + 4; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      if (tx_busy) busy_cnt++;
      if ((i % BIT_CLKS) == BIT_CLKS / 2 && (i / BIT_CLKS) < int'(FRAME_BITS)) begin
        check_eq($sformatf("tx_bit%0d", i / BIT_CLKS), 32'(tx), 32'(bits[i/BIT_CLKS]));
      end
    end
    check_eq("tx_busy_len", 32'(busy_cnt), 32'(FRAME_BITS * BIT_CLKS));
    check_eq("tx_idle_after", 32'(tx), 32'd1);
  endtask

  task automatic drive_rx_frame(input logic [DATA_W-1:0] d, input logic flip, input logic stop_ok);
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < int'(DATA_W); i++) begin
      rx_drv = d[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    if (P != 0) begin
      rx_drv = ^d ^ p_sel ^ flip;
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx_drv = stop_ok;
    // A bad stop bit is kept short so the line is high again when the next start check runs.
    if (stop_ok) repeat (BIT_CLKS) @(negedge clk);
    else repeat (12) @(negedge clk);
    rx_drv = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
  endtask

  task automatic wait_sb_empty(input string tag, input int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check_eq(tag, 32'(sb_q.size()), 32'd0);
    repeat (20) @(posedge clk);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int cnt;
    rst      = 1'b0;
    tx_start = 1'b0;
    tx_data  = '0;
    p_sel    = 1'b0;
    rx_drv   = 1'b1;
    loop     = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_tx", 32'(tx), 32'd1);
    check_eq("rst_tx_busy", 32'(tx_busy), 32'd0);
    check_eq("rst_rx_data", 32'(rx_data), 32'd0);
    check_eq("rst_rx_valid", 32'(rx_valid), 32'd0);
    check_eq("rst_p_err", 32'(p_err), 32'd0);
    check_eq("rst_f_err", 32'(f_err), 32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // All-ones word, even parity, looped back.
    sb_q.push_back('{data: 8'hFF, p_err: 1'b0, f_err: 1'b0});
    check_tx_frame(8'hFF, 1'b0);
    wait_sb_empty("sb_ff", 400);

    // Odd parity loopback.
    sb_q.push_back('{data: 8'hA5, p_err: 1'b0, f_err: 1'b0});
    check_tx_frame(8'hA5, 1'b1);
    wait_sb_empty("sb_a5", 400);

    // Bench-driven RX: parity inverted, then bad stop bit.
    loop  = 1'b0;
    p_sel = 1'b0;
    sb_q.push_back('{data: 8'h3C, p_err: (P != 0), f_err: 1'b0});
    drive_rx_frame(8'h3C, 1'b1, 1'b1);
    wait_sb_empty("sb_3c", 400);
    sb_q.push_back('{data: 8'h96, p_err: 1'b0, f_err: 1'b1});
    drive_rx_frame(8'h96, 1'b0, 1'b0);
    wait_sb_empty("sb_96", 400);

    // Short glitch must be rejected, next frame still received.
    cnt = n_rx_valid;
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (60) @(negedge clk);
    check_eq("glitch_no_valid", 32'(n_rx_valid), 32'(cnt));
    sb_q.push_back('{data: 8'h5A, p_err: 1'b0, f_err: 1'b0});
    drive_rx_frame(8'h5A, 1'b0, 1'b1);
    wait_sb_empty("sb_5a", 400);

    // Reset in the middle of the third data bit.
    loop = 1'b1;
    cnt  = n_rx_valid;
    pulse_tx(8'h33, 1'b0);
    repeat (3 * BIT_CLKS + BIT_CLKS / 2) @(posedge clk);
    #1;
    check_eq("busy_before_rst", 32'(tx_busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check_eq("mid_rst_tx", 32'(tx), 32'd1);
    check_eq("mid_rst_tx_busy", 32'(tx_busy), 32'd0);
    check_eq("mid_rst_rx_data", 32'(rx_data), 32'd0);
    check_eq("mid_rst_f_err", 32'(f_err), 32'd0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (60) @(negedge clk);
    check_eq("no_rx_after_rst", 32'(n_rx_valid), 32'(cnt));
    sb_q.push_back('{data: 8'h81, p_err: 1'b0, f_err: 1'b0});
    check_tx_frame(8'h81, 1'b0);
    wait_sb_empty("sb_81", 400);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
